sklansky_sub32_pipe: RTL and testbench

//  Two-stage pipelined 32-bit subtractor: diff = a - b - bin. Uses the team's Sklansky prefix

---
 rtl/sklansky_sub32_pipe.sv | 173 +++++++++++++++++
 tb/tb_sklansky_sub32_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sklansky_sub32_pipe.sv
// Two-stage pipelined 32-bit subtractor (diff = a - b - bin) built on Sklansky prefix carry trees.
// Stage 1 resolves the low half and its carry; stage 2 resolves the high half and the flags.
module sklansky_sub32_pipe #(
  parameter int unsigned Width = 32,
  parameter int unsigned Half  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned Levels = $clog2(Half);

  // Sklansky prefix over one half; returns carries c[0..Half] with c[0] = cin.
  function automatic logic [Half:0] sk_carries(input logic [Half-1:0] p,
                                               input logic [Half-1:0] g,
                                               input logic            cin);
    logic [Half-1:0] gg;
    logic [Half-1:0] pp;
    logic [Half:0]   c;
    int unsigned     j;
    gg = g;
    pp = p;
    j  = 0;
    // At level l node j always has bit l clear, so in-place update reads last-level values.
    for (int unsigned l = 0; l < Levels; l++) begin
      for (int unsigned i = 0; i < Half; i++) begin
        if (((i >> l) % 2) == 1) begin
          j     = ((i >> l) << l) - 1;
          gg[i] = gg[i] | (pp[i] & gg[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
    end
    c[0] = cin;
    for (int unsigned i = 0; i < Half; i++) begin
      c[i+1] = gg[i] | (pp[i] & cin);
    end
    return c;
  endfunction

  // Handshake state
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_ready;
  logic s1_load;
  logic s2_load;

  // Stage-1 registers
  logic [Half-1:0]       s1_diff_lo_q, s1_diff_lo_d;
  logic                  s1_c16_q, s1_c16_d;
  logic [Width-Half-1:0] s1_a_hi_q, s1_a_hi_d;
  logic [Width-Half-1:0] s1_nb_hi_q, s1_nb_hi_d;
  logic                  s1_sx_q, s1_sx_d;

  // Stage-2 (output) registers
  logic [Width-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  assign s2_ready   = !out_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_ready;
  assign s1_load    = in_ready_o && in_valid_i;
  assign s2_load    = s1_valid_q && s2_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (in_ready_o) begin
      s1_valid_d = in_valid_i;
    end
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
    end
  end

  // Stage 1: low-half prefix over (a, ~b) with carry-in ~bin.
  logic [Width-1:0] nb;
  logic [Half-1:0]  p_lo;
  logic [Half-1:0]  g_lo;
  logic [Half:0]    c_lo;

  always_comb begin
    nb           = ~b_i;
    p_lo         = a_i[Half-1:0] ^ nb[Half-1:0];
    g_lo         = a_i[Half-1:0] & nb[Half-1:0];
    c_lo         = sk_carries(p_lo, g_lo, ~bin_i);
    s1_diff_lo_d = p_lo ^ c_lo[Half-1:0];
    s1_c16_d     = c_lo[Half];
    s1_a_hi_d    = a_i[Width-1:Half];
    s1_nb_hi_d   = nb[Width-1:Half];
    s1_sx_d      = a_i[Width-1] ^ b_i[Width-1];
  end

  // Stage 2: high-half prefix seeded with the registered c16.
  logic [Width-Half-1:0] p_hi;
  logic [Width-Half-1:0] g_hi;
  logic [Half:0]         c_hi;
  logic [Width-Half-1:0] diff_hi;

  always_comb begin
    p_hi    = s1_a_hi_q ^ s1_nb_hi_q;
    g_hi    = s1_a_hi_q & s1_nb_hi_q;
    c_hi    = sk_carries(p_hi, g_hi, s1_c16_q);
    diff_hi = p_hi ^ c_hi[Half-1:0];
    diff_d  = {diff_hi, s1_diff_lo_q};
    bout_d  = ~c_hi[Half];
    ovf_d   = s1_sx_q && (diff_hi[Width-Half-1] != s1_a_hi_q[Width-Half-1]);
    zero_d  = ~|diff_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Data registers only move on a real transfer so idle beats never inject X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_diff_lo_q <= '0;
      s1_c16_q     <= 1'b0;
      s1_a_hi_q    <= '0;
      s1_nb_hi_q   <= '0;
      s1_sx_q      <= 1'b0;
    end else if (s1_load) begin
      s1_diff_lo_q <= s1_diff_lo_d;
      s1_c16_q     <= s1_c16_d;
      s1_a_hi_q    <= s1_a_hi_d;
      s1_nb_hi_q   <= s1_nb_hi_d;
      s1_sx_q      <= s1_sx_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (s2_load) begin
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign diff_o      = diff_q;
  assign bout_o      = bout_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;

  stall_hold_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_q && !out_ready_i) |=> (out_valid_q && $stable(diff_q) && $stable(bout_q)));

endmodule

// File: tb/tb_sklansky_sub32_pipe.sv
// Self-checking bench for sklansky_sub32_pipe: directed arithmetic corners, reset, backpressure
// and a randomised stream scored against a plain a - b - bin reference.
module tb_sklansky_sub32_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  sklansky_sub32_pipe dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .bin_i      (bin),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .diff_o     (diff),
    .bout_o     (bout),
    .ovf_o      (ovf),
    .zero_o     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {diff, bout, ovf, zero}
  function automatic logic [34:0] model(input logic [31:0] a_v, input logic [31:0] b_v,
                                        input logic bin_v);
    logic [32:0] r;
    logic [31:0] d;
    r = {1'b0, a_v} - {1'b0, b_v} - {32'd0, bin_v};
    d = r[31:0];
    return {d, r[32], (a_v[31] != b_v[31]) && (d[31] != a_v[31]), d == 32'd0};
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  logic [34:0] exp_q[$];
  logic        sb_en = 1'b0;
  logic        hold_prev = 1'b0;
  logic [34:0] held = '0;
  int          n_out = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (hold_prev) begin
        check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("hold_data", {29'd0, diff, bout, ovf, zero}, {29'd0, held});
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check_eq("sb_extra_out", {63'd0, out_valid}, 64'd0);
        else check_eq("sb_result", {29'd0, diff, bout, ovf, zero}, {29'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
      hold_prev = out_valid && !out_ready;
      held      = {diff, bout, ovf, zero};
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic run_single(input string tag, input logic [31:0] a_v, input logic [31:0] b_v,
                            input logic bin_v, input logic [31:0] e_diff, input logic e_bout,
                            input logic e_ovf, input logic e_zero);
    in_valid  = 1'b1;
    a         = a_v;
    b         = b_v;
    bin       = bin_v;
    out_ready = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_early"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_diff"}, {32'd0, diff}, {32'd0, e_diff});
    check_eq({tag, "_bout"}, {63'd0, bout}, {63'd0, e_bout});
    check_eq({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e_ovf});
    check_eq({tag, "_zero"}, {63'd0, zero}, {63'd0, e_zero});
    @(posedge clk); #1;
    check_eq({tag, "_drained"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int i;
    int k;
    int base;
    int sent;
    int stalls;
    logic saw_block;
    logic fired;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_diff", {32'd0, diff}, 64'd0);
    check_eq("rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: fill both stages under backpressure, then reset asynchronously mid-cycle.
    in_valid = 1'b1; a = 32'h0000_0100; b = 32'h1; bin = 1'b0;
    @(posedge clk); #1;
    a = 32'h0000_0200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("t1_full_valid", {63'd0, out_valid}, 64'd1);
    check_eq("t1_full_blocked", {63'd0, in_ready}, 64'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("t1_async_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t1_async_ready", {63'd0, in_ready}, 64'd1);
    check_eq("t1_async_diff", {32'd0, diff}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check_eq("t1_no_stale", {63'd0, out_valid}, 64'd0);
    end

    // T2-T4: directed corners with hand-computed results.
    run_single("t2_basic", 32'h0000_000A, 32'h3, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    run_single("t3_borrow", 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_single("t3_equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    run_single("t4_ovf_neg", 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_single("t4_ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1,
               1'b0);
    run_single("half_cross", 32'h0001_0000, 32'h1, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    run_single("max_bin", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // T5: eight beats against out_ready pattern 1,0,0,1.
    sb_en = 1'b1;
    base = n_out; i = 0; k = 0; saw_block = 1'b0;
    while ((i < 8 || exp_q.size() != 0) && k < 200) begin
      out_ready = pat[k % 4];
      in_valid  = (i < 8);
      a         = 32'(i) * 32'h0101_0101;
      b         = 32'(i);
      bin       = 1'b0;
      @(negedge clk);
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("t5_sent", 64'(i), 64'd8);
    check_eq("t5_results", 64'(n_out - base), 64'd8);
    check_eq("t5_in_ready_dropped", {63'd0, saw_block}, 64'd1);
    check_eq("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // T6: random valid/ready/operands.
    sent = 0; k = 0; fired = 1'b0;
    while (sent < 10000 && k < 60000) begin
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a        = $urandom;
        b        = $urandom;
        bin      = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      fired = in_valid && in_ready;
      if (fired) sent++;
      @(posedge clk); #1;
      k++;
    end
    check_eq("t6_sent", 64'(sent), 64'd10000);

    // Full-rate window: with both sides always ready the pipe must never bubble.
    stalls = 0;
    for (int n = 0; n < 64; n++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = $urandom;
      b         = $urandom;
      bin       = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!in_ready || (n >= 2 && !out_valid)) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("t6_full_rate_stalls", 64'(stalls), 64'd0);

    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("t6_drain", 64'(exp_q.size()), 64'd0);
    sb_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
